// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin arbiter/sequencer sharing one multi-cycle FP32
// adder between N_REQ requesters, with a watchdog abort on the adder.
// Optional feature: define FPARB_ZERO_BYPASS_EN to skip the adder when one
// operand is +/-0 and return the other operand directly.
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [32*N_REQ-1:0]      req_x,
    input  logic [32*N_REQ-1:0]      req_y,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_z,
    output logic [1:0]               resp_ovf,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic                     add_start,
    output logic [31:0]              add_x,
    output logic [31:0]              add_y,
    input  logic [31:0]              add_z,
    input  logic [1:0]               add_ovf,
    input  logic                     add_done
);

    localparam int          ID_W  = $clog2(N_REQ);
    localparam int          CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned NR    = N_REQ;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, next_state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [31:0]       sel_x, sel_y;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_hit;
    logic              bypass;
    logic [31:0]       bypass_z;

`ifdef FPARB_ZERO_BYPASS_EN
    logic x_zero, y_zero;
    assign x_zero   = (add_x[30:0] == 31'd0);
    assign y_zero   = (add_y[30:0] == 31'd0);
    assign bypass   = x_zero || y_zero;
    assign bypass_z = x_zero ? add_y : add_x;
`else
    assign bypass   = 1'b0;
    assign bypass_z = '0;
`endif

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

    // Round-robin search starting one past the last served requester
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            cand = ID_W'((32'(last_grant) + 32'd1 + i) % NR);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        sel_x = req_x[32*winner +: 32];
        sel_y = req_y[32*winner +: 32];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic and handshake/strobe outputs
    always_comb begin
        next_state = state;
        req_ready  = '0;
        add_start  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    next_state        = ISSUE;
                end
            end
            ISSUE: begin
                if (bypass) begin
                    next_state = RESP;
                end else begin
                    add_start  = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (add_done || timeout_hit) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Outputs read as cleared while reset is asserted
        if (!rst) begin
            req_ready  = '0;
            add_start  = 1'b0;
            resp_valid = 1'b0;
        end
    end

    // Operand/result latches, watchdog counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            add_x      <= '0;
            add_y      <= '0;
            resp_z     <= '0;
            resp_ovf   <= '0;
            resp_id    <= '0;
            cnt        <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        add_x   <= sel_x;
                        add_y   <= sel_y;
                        resp_id <= winner;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (bypass) begin
                        resp_z   <= bypass_z;
                        resp_ovf <= 2'b00;
                    end
                end
                WAIT: begin
                    // A done pulse coinciding with the timeout returns the real result
                    if (add_done) begin
                        resp_z   <= add_z;
                        resp_ovf <= add_ovf;
                    end else if (timeout_hit) begin
                        resp_z   <= 32'hFFFF_FFFF;
                        resp_ovf <= 2'b11;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) last_grant <= resp_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: vector table plus hand-written sequences
// for round-robin order, response backpressure, and reset during WAIT.
module tb_fp_add_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_x, req_y;
    logic [N-1:0]    req_ready;
    logic            resp_valid, resp_ready;
    logic [31:0]     resp_z;
    logic [1:0]      resp_ovf;
    logic [1:0]      resp_id;
    logic            add_start;
    logic [31:0]     add_x, add_y, add_z;
    logic [1:0]      add_ovf;
    logic            add_done;

    int checks = 0;
    int errors = 0;

    int          start_cnt = 0;
    int          cur_lat   = 1;
    logic [31:0] cur_z     = '0;
    logic [1:0]  cur_ovf   = '0;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        int          lat;     // adder latency after start, -1 = never done
        logic [31:0] z;
        logic [1:0]  ovf;
        logic [31:0] ez;
        logic [1:0]  eovf;
        int          elat;    // cycles from accept to resp_valid
        int          estarts; // expected add_start pulses
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    fp_add_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
        .resp_ovf(resp_ovf), .resp_id(resp_id),
        .add_start(add_start), .add_x(add_x), .add_y(add_y),
        .add_z(add_z), .add_ovf(add_ovf), .add_done(add_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " req_ready"},  32'(req_ready),  32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_z"},     resp_z,          32'd0);
        chk({tag, " resp_ovf"},   32'(resp_ovf),   32'd0);
        chk({tag, " resp_id"},    32'(resp_id),    32'd0);
        chk({tag, " add_start"},  32'(add_start),  32'd0);
        chk({tag, " add_x"},      add_x,           32'd0);
        chk({tag, " add_y"},      add_y,           32'd0);
    endtask

    // Adder model: pulses add_done cur_lat cycles after an observed add_start
    initial begin
        add_done = 1'b0;
        add_z    = '0;
        add_ovf  = '0;
        forever begin
            @(negedge clk); #1;
            if (add_start === 1'b1) begin
                start_cnt++;
                if (cur_lat >= 0) begin
                    repeat (cur_lat) @(negedge clk);
                    add_z    = cur_z;
                    add_ovf  = cur_ovf;
                    add_done = 1'b1;
                    @(negedge clk);
                    add_done = 1'b0;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int base, n, k;
        base    = start_cnt;
        cur_lat = v.lat;
        cur_z   = v.z;
        cur_ovf = v.ovf;
        @(negedge clk);
        req_x[32*v.id +: 32] = v.x;
        req_y[32*v.id +: 32] = v.y;
        req_valid[v.id]      = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
        chk({tag, " grant"}, 32'(req_ready), 32'(1 << v.id));
        @(negedge clk);
        req_valid = '0;
        #1;
        k = 1;
        while (resp_valid !== 1'b1 && k < 200) begin @(negedge clk); #1; k++; end
        chk({tag, " latency"}, 32'(k), 32'(v.elat));
        chk({tag, " resp_z"}, resp_z, v.ez);
        chk({tag, " resp_ovf"}, 32'(resp_ovf), 32'(v.eovf));
        chk({tag, " resp_id"}, 32'(resp_id), 32'(v.id));
        chk({tag, " add_x"}, add_x, v.x);
        chk({tag, " add_y"}, add_y, v.y);
        chk({tag, " starts"}, 32'(start_cnt - base), 32'(v.estarts));
        resp_ready = 1'b1;
        @(negedge clk); #1;
        chk({tag, " valid drop"}, 32'(resp_valid), 32'd0);
        resp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, cyc, prev_cyc, n, bad;
        rst        = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;

        tbl[0] = '{2, 32'h3F800000, 32'h40000000, 5,  32'h40400000, 2'b00, 32'h40400000, 2'b00, 7,  1};
        tbl[1] = '{0, 32'h40000000, 32'h40000000, 1,  32'h40800000, 2'b00, 32'h40800000, 2'b00, 3,  1};
        tbl[2] = '{3, 32'h7F000000, 32'h7F000000, 3,  32'h7F800000, 2'b01, 32'h7F800000, 2'b01, 5,  1};
        tbl[3] = '{1, 32'h00800000, 32'h80800001, 2,  32'h80000001, 2'b10, 32'h80000001, 2'b10, 4,  1};
`ifdef FPARB_ZERO_BYPASS_EN
        tbl[4] = '{1, 32'h00000000, 32'hC0A00000, 4,  32'hC0A00000, 2'b00, 32'hC0A00000, 2'b00, 2,  0};
`else
        tbl[4] = '{1, 32'h00000000, 32'hC0A00000, 4,  32'hC0A00000, 2'b00, 32'hC0A00000, 2'b00, 6,  1};
`endif
        tbl[5] = '{2, 32'h3F800000, 32'hBF800000, -1, 32'h00000000, 2'b00, 32'hFFFFFFFF, 2'b11, 67, 1};
        tbl[6] = '{0, 32'h12340000, 32'h01000000, 65, 32'h12345678, 2'b00, 32'h12345678, 2'b00, 67, 1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("reset");

        // Round-robin with all requesters valid from reset
        cur_lat = 1; cur_z = 32'h3F800000; cur_ovf = 2'b00;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_x[32*i +: 32] = 32'h40000000 + 32'(i);
            req_y[32*i +: 32] = 32'h3F000000;
        end
        req_valid = '1;
        g = 0; cyc = 0; prev_cyc = -1;
        while (g < 5 && cyc < 100) begin
            #1;
            if (req_ready != '0) begin
                chk($sformatf("rr grant%0d", g), 32'(req_ready), 32'(1 << (g % N)));
                if (prev_cyc >= 0) chk($sformatf("rr gap%0d", g), 32'(cyc - prev_cyc), 32'd4);
                prev_cyc = cyc;
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rr count", 32'(g), 32'd5);
        req_valid = '0;
        repeat (6) @(negedge clk);
        resp_ready = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: response held for 10 cycles while requester 3 waits
        cur_lat = 2; cur_z = 32'h3E000000; cur_ovf = 2'b00;
        @(negedge clk);
        req_x[32*1 +: 32] = 32'h3D000000;
        req_y[32*1 +: 32] = 32'h3D000000;
        req_valid[1] = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
        chk("bp grant1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        req_x[32*3 +: 32] = 32'h41000000;
        req_valid[3] = 1'b1;
        #1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_z !== 32'h3E000000 || resp_id !== 2'd1 || req_ready !== '0)
                bad++;
            @(negedge clk); #1;
        end
        chk("bp hold stable", 32'(bad), 32'd0);
        chk("bp resp_z", resp_z, 32'h3E000000);
        resp_ready = 1'b1;
        chk("bp no grant in handshake", 32'(req_ready), 32'd0);
        @(negedge clk); #1;
        resp_ready = 1'b0;
        chk("bp valid drop", 32'(resp_valid), 32'd0);
        chk("bp grant3 after", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        #1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        chk("bp resp_id3", 32'(resp_id), 32'd3);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset mid-WAIT: served id 0 last, so a kept pointer would favour 3
        run_vec(tbl[1], "pre");
        cur_lat = 8; cur_z = 32'h11111111; cur_ovf = 2'b00;
        @(negedge clk);
        req_x[32*2 +: 32] = 32'h40400000;
        req_valid[2] = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
        chk("rw grant2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("after reset");
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (resp_valid !== 1'b0 || add_start !== 1'b0) bad++;
        end
        chk("rw no response", 32'(bad), 32'd0);
        cur_lat = 1;
        req_valid = 4'b1001;
        #1;
        chk("rw first priority", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (6) @(negedge clk);
        resp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle FP32 adder between `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues one operation at a time to the adder with a start pulse. It then waits for the adder's done pulse, or a watchdog timeout, and returns the result with its requester ID on a single valid/ready response port. It sits between the vector/accumulator front-ends and the shared `fpadder` instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum adder cycles from `add_start` to `add_done` before abort (≥ 8).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_x`  in  32*N_REQ  operand x of requester i, bits [32i+31:32i].
- `req_y`  in  32*N_REQ  operand y of requester i.
- `req_ready`  out  N_REQ  one-hot accept pulse; a request transfers when valid&ready.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_z`  out  32  FP32 sum.
- `resp_ovf`  out  2  status: 00 ok, 01 overflow, 10 underflow, 11 invalid/abort.
- `resp_id`  out  $clog2(N_REQ)  index of the originating requester.
- `add_start`  out  1  one-cycle launch pulse to the adder.
- `add_x`, `add_y`  out  32  adder operands; held stable from `add_start` until the operation completes.
- `add_z`  in  32  adder result; valid on `add_done`.
- `add_ovf`  in  2  adder status; valid on `add_done`.
- `add_done`  in  1  one-cycle completion pulse from the adder.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, select the winner by round-robin. The search starts at `last_grant+1` modulo `N_REQ`.
  - Assert `req_ready[winner]` for exactly that cycle.
  - Latch the winner's x and y into `add_x`/`add_y` and latch the winner's index into `resp_id`.
  - Go to ISSUE.
- ISSUE: `add_start`=1 for one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On `add_done`: capture `add_z` and `add_ovf` into `resp_z`/`resp_ovf`; go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: `resp_z`=32'hFFFFFFFF, `resp_ovf`=2'b11; go to RESP.
  - `add_done` in the same cycle as the timeout wins; the real result is returned.
- RESP:
  - `resp_valid`=1, with `resp_z`/`resp_ovf`/`resp_id` held stable until `resp_ready`.
  - On handshake: set `last_grant` to `resp_id` and go to IDLE.
  - `resp_valid` drops in the cycle after the handshake.
- `add_done` outside WAIT is ignored.
- Requests arriving outside IDLE are not accepted; `req_ready` stays 0.
- Requesters must hold `req_valid`, `req_x` and `req_y` until accepted.
- Only one operation is outstanding at a time. No queueing and no reordering.
- Reset (any state, including mid-WAIT):
  - Go to IDLE.
  - Clear all outputs to 0: `req_ready`, `resp_valid`, `resp_z`, `resp_ovf`, `resp_id`, `add_start`, `add_x`, `add_y`.
  - Set `last_grant`=N_REQ-1, so requester 0 has first priority.
  - An aborted operation produces no response. A late `add_done` after reset is ignored.

## Timing
- Accept cycle A: `req_ready` is high in cycle A.
- `add_start` is high in A+1.
- Earliest `add_done` is in A+2, which gives `resp_valid` in A+3.
- Result latency = adder latency + 2 cycles from accept to `resp_valid`.
- Minimum spacing between accepts: 4 cycles (IDLE→ISSUE→WAIT→RESP→IDLE), with zero-wait `resp_ready`.
- A timeout asserts `resp_valid` `TIMEOUT`+2 cycles after `add_start`.

## Configuration
- Macro `FPARB_ZERO_BYPASS_EN`:
  - Defined:
    - In ISSUE, if the x exponent and mantissa are both 0, do not pulse `add_start`; load `resp_z`=y and `resp_ovf`=00, and go directly to RESP.
    - Else if y is ±0, load `resp_z`=x in the same way.
    - Result latency: 2 cycles from accept.
  - Undefined: every request goes through the adder.

## Test plan
- Single request, id 2: x=32'h3F800000, y=32'h40000000, adder done 5 cycles after start, z=32'h40400000 → resp_id=2, resp_z=32'h40400000, resp_ovf=00; `resp_valid` 7 cycles after accept.
- All 4 `req_valid` held high continuously after reset → grant order 0,1,2,3,0; each `req_ready` is exactly one cycle wide.
- `resp_ready` held low for 10 cycles in RESP → `resp_valid`/`resp_z`/`resp_id` stable throughout; no new `req_ready` until the cycle after the handshake.
- `add_done` never asserted, `TIMEOUT`=64 → `resp_valid` 66 cycles after `add_start`, resp_z=32'hFFFFFFFF, resp_ovf=11.
- `rst`=0 for one cycle during WAIT, then `add_done` pulses → no response; all outputs 0; the next request from requester 0 is granted first.
- With `FPARB_ZERO_BYPASS_EN`: x=32'h00000000, y=32'hC0A00000 → no `add_start`, resp_z=32'hC0A00000 two cycles after accept. Without the macro, `add_start` pulses.
